// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolution-side update bundle for branch_predictor.
// The pipeline is the master; the predictor is the slave.
interface branch_predictor_if;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  modport master (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_type, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_type, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters and a circular return-address
// stack; zero-latency lookup, non-speculative update at resolution.
module branch_predictor #(
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int RAS_PW  = $clog2(RAS_DEPTH);

  localparam logic [1:0] T_BR  = 2'b00;
  localparam logic [1:0] T_J   = 2'b01;
  localparam logic [1:0] T_JAL = 2'b10;
  localparam logic [1:0] T_JR  = 2'b11;

  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
  localparam logic [RAS_PW:0]   RAS_FULL = (RAS_PW + 1)'(RAS_DEPTH);
  localparam logic [RAS_PW:0]   RAS_NONE = '0;
  localparam logic [RAS_PW-1:0] PTR_ONE  = RAS_PW'(1);
  localparam logic [RAS_PW:0]   CNTR_ONE = (RAS_PW + 1)'(1);

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic up);
    logic [CNT_W-1:0] r;
    r = c;
    if (up) begin
      if (c != CNT_MAX) r = c + CNT_ONE;
      else              r = c;
    end else begin
      if (c != CNT_ZERO) r = c - CNT_ONE;
      else               r = c;
    end
    return r;
  endfunction

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [1:0]       type_q  [ENTRIES];
  logic [29:0]      tgt_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];

  logic [31:0]       ras_q [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_ptr_q, ras_ptr_d;
  logic [RAS_PW:0]   ras_cnt_q, ras_cnt_d;
  logic [RAS_PW-1:0] ras_top_idx_s;
  logic              ras_push_s;

  logic [IDX_W-1:0] lk_idx_s, u_idx_s;
  logic [TAG_W-1:0] lk_tag_s, u_tag_s;
  logic             lk_hit_s, u_hit_s, u_write_s;
  logic             lk_taken_s;
  logic [31:0]      lk_tgt_s, lk_pc4_s, u_pc4_s;
  logic [CNT_W-1:0] ent_cnt_d;

  assign lk_idx_s      = bp.lk_pc[IDX_W+1:2];
  assign lk_tag_s      = bp.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx_s       = bp.upd_pc[IDX_W+1:2];
  assign u_tag_s       = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_pc4_s      = bp.lk_pc + 32'd4;
  assign u_pc4_s       = bp.upd_pc + 32'd4;
  assign ras_top_idx_s = ras_ptr_q - PTR_ONE;

  assign lk_hit_s  = rst_n & bp.lk_valid & valid_q[lk_idx_s] & (tag_q[lk_idx_s] == lk_tag_s);
  assign u_hit_s   = valid_q[u_idx_s] & (tag_q[u_idx_s] == u_tag_s);
  assign u_write_s = bp.upd_valid & (u_hit_s | bp.upd_taken);
  assign ent_cnt_d = u_hit_s ? sat_step(cnt_q[u_idx_s], bp.upd_taken) : CNT_WEAK;

  // Lookup: direction and target from the entry, or the RAS top for returns
  always_comb begin
    lk_taken_s = 1'b0;
    lk_tgt_s   = {tgt_q[lk_idx_s], 2'b00};
    if (lk_hit_s) begin
      case (type_q[lk_idx_s])
        T_BR:       lk_taken_s = cnt_q[lk_idx_s][CNT_W-1];
        T_J, T_JAL: lk_taken_s = 1'b1;
        T_JR: begin
          lk_taken_s = (ras_cnt_q != RAS_NONE);
          lk_tgt_s   = ras_q[ras_top_idx_s];
        end
        default:    lk_taken_s = 1'b0;
      endcase
    end else begin
      lk_taken_s = 1'b0;
    end
  end

  assign bp.pred_taken  = lk_taken_s;
  assign bp.pred_target = lk_taken_s ? lk_tgt_s : lk_pc4_s;

  assign bp.mispredict  = bp.upd_valid &
                          ((bp.upd_taken != bp.upd_pred_taken) |
                           (bp.upd_taken & (bp.upd_target != bp.upd_pred_target)));
  assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : u_pc4_s;

  // RAS next state: a full push drops the oldest entry, an empty pop does nothing
  always_comb begin
    ras_ptr_d  = ras_ptr_q;
    ras_cnt_d  = ras_cnt_q;
    ras_push_s = 1'b0;
    if (bp.upd_valid) begin
      case (bp.upd_type)
        T_JAL: begin
          ras_push_s = 1'b1;
          ras_ptr_d  = ras_ptr_q + PTR_ONE;
          if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + CNTR_ONE;
          else                       ras_cnt_d = ras_cnt_q;
        end
        T_JR: begin
          if (ras_cnt_q != RAS_NONE) begin
            ras_ptr_d = ras_ptr_q - PTR_ONE;
            ras_cnt_d = ras_cnt_q - CNTR_ONE;
          end else begin
            ras_ptr_d = ras_ptr_q;
            ras_cnt_d = ras_cnt_q;
          end
        end
        default: begin
          ras_ptr_d = ras_ptr_q;
          ras_cnt_d = ras_cnt_q;
        end
      endcase
    end else begin
      ras_push_s = 1'b0;
    end
  end

  // Table and RAS state; the whole entry is written in one edge so reset never leaves a torn entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        type_q[i]  <= 2'b00;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      for (int j = 0; j < RAS_DEPTH; j++) begin
        ras_q[j] <= 32'd0;
      end
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      if (u_write_s) begin
        valid_q[u_idx_s] <= 1'b1;
        tag_q[u_idx_s]   <= u_tag_s;
        type_q[u_idx_s]  <= bp.upd_type;
        tgt_q[u_idx_s]   <= bp.upd_target[31:2];
        cnt_q[u_idx_s]   <= ent_cnt_d;
      end
      if (ras_push_s) begin
        ras_q[ras_ptr_q] <= u_pc4_s;
      end
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations
// (default parameters: IDX_W=6, TAG_W=8, CNT_W=2, RAS_DEPTH=4).
module tb_branch_predictor;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  branch_predictor_if bp ();

  branch_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic lk(input string tag, input logic [31:0] pc, input logic exp_tk,
                    input logic [31:0] exp_tgt);
    bp.lk_pc = pc;
    #1;
    check_eq({tag, ".taken"}, {31'd0, bp.pred_taken}, {31'd0, exp_tk});
    check_eq({tag, ".target"}, bp.pred_target, exp_tgt);
  endtask

  task automatic upd_start(input logic [1:0] ty, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    bp.upd_valid       = 1'b1;
    bp.upd_type        = ty;
    bp.upd_pc          = pc;
    bp.upd_taken       = tk;
    bp.upd_target      = tgt;
    bp.upd_pred_taken  = ptk;
    bp.upd_pred_target = ptgt;
  endtask

  task automatic upd_end();
    @(posedge clk);
    #1;
    bp.upd_valid = 1'b0;
  endtask

  task automatic upd(input string tag, input logic [1:0] ty, input logic [31:0] pc,
                     input logic tk, input logic [31:0] tgt, input logic ptk,
                     input logic [31:0] ptgt, input logic exp_mp, input logic [31:0] exp_rd);
    upd_start(ty, pc, tk, tgt, ptk, ptgt);
    #1;
    check_eq({tag, ".mispredict"}, {31'd0, bp.mispredict}, {31'd0, exp_mp});
    check_eq({tag, ".redirect"}, bp.redirect_pc, exp_rd);
    upd_end();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] top;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bp.lk_valid        = 1'b1;
    bp.lk_pc           = 32'h40;
    bp.upd_valid       = 1'b1;
    bp.upd_type        = 2'b00;
    bp.upd_pc          = 32'h40;
    bp.upd_taken       = 1'b1;
    bp.upd_target      = 32'h80;
    bp.upd_pred_taken  = 1'b0;
    bp.upd_pred_target = 32'h44;

    // Reset: lookups miss, updates ignored, mispredict still combinational
    #1;
    check_eq("rst.taken", {31'd0, bp.pred_taken}, 32'd0);
    check_eq("rst.target", bp.pred_target, 32'h44);
    check_eq("rst.mispredict", {31'd0, bp.mispredict}, 32'd1);
    check_eq("rst.redirect", bp.redirect_pc, 32'h80);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    bp.upd_valid = 1'b0;
    lk("post_rst", 32'h40, 1'b0, 32'h44);

    // Allocate beq at 0x40; same-cycle lookup sees pre-update contents
    bp.lk_pc = 32'h40;
    upd_start(2'b00, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    check_eq("alloc.mispredict", {31'd0, bp.mispredict}, 32'd1);
    check_eq("alloc.redirect", bp.redirect_pc, 32'h80);
    check_eq("same_cycle.taken", {31'd0, bp.pred_taken}, 32'd0);
    upd_end();
    lk("alloc", 32'h40, 1'b1, 32'h80);

    upd("nt1", 2'b00, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
    lk("cnt1", 32'h40, 1'b0, 32'h44);
    upd("nt2", 2'b00, 32'h40, 1'b0, 32'h80, 1'b0, 32'h44, 1'b0, 32'h44);
    lk("cnt0", 32'h40, 1'b0, 32'h44);

    for (int i = 0; i < 4; i++) begin
      upd("tk", 2'b00, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
    end
    lk("cnt3", 32'h40, 1'b1, 32'h80);
    upd("sat_nt", 2'b00, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
    lk("cnt2", 32'h40, 1'b1, 32'h80);
    lk("alias", 32'h140, 1'b0, 32'h144);
    upd("nt3", 2'b00, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
    lk("cnt1b", 32'h40, 1'b0, 32'h44);

    // Target mismatch alone is a mispredict; entry target is rewritten
    upd("tgt_mm", 2'b00, 32'h40, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90);
    lk("new_tgt", 32'h40, 1'b1, 32'h90);

    upd("nt_miss", 2'b01, 32'h300, 1'b0, 32'h400, 1'b0, 32'h304, 1'b0, 32'h304);
    lk("no_alloc", 32'h300, 1'b0, 32'h304);
    lk("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    bp.lk_valid = 1'b0;
    lk("lk_off", 32'h40, 1'b0, 32'h44);
    bp.lk_valid = 1'b1;

    // Call/return through the RAS
    upd("jal1", 2'b10, 32'h100, 1'b1, 32'h1000, 1'b0, 32'h104, 1'b1, 32'h1000);
    lk("jal_hit", 32'h100, 1'b1, 32'h1000);
    upd("jal2", 2'b10, 32'h100, 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b0, 32'h1000);
    upd("jr1", 2'b11, 32'h200, 1'b1, 32'h104, 1'b0, 32'h204, 1'b1, 32'h104);
    lk("jr_ras", 32'h200, 1'b1, 32'h104);
    upd("jr2", 2'b11, 32'h200, 1'b1, 32'h104, 1'b1, 32'h104, 1'b0, 32'h104);
    lk("jr_empty", 32'h200, 1'b0, 32'h204);

    // Overflow: five pushes, four pops return 5th..2nd, fifth pop is a no-op
    for (int i = 1; i <= 5; i++) begin
      upd("push", 2'b10, 32'h10 + 32'h1000 * i, 1'b1, 32'h8000, 1'b1, 32'h8000, 1'b0, 32'h8000);
    end
    for (int i = 0; i < 4; i++) begin
      top = 32'h5014 - 32'h1000 * i;
      lk("ras_top", 32'h200, 1'b1, top);
      upd("pop", 2'b11, 32'h200, 1'b1, top, 1'b1, top, 1'b0, top);
    end
    lk("ras_drained", 32'h200, 1'b0, 32'h204);
    upd("pop_empty", 2'b11, 32'h200, 1'b1, 32'h104, 1'b0, 32'h204, 1'b1, 32'h104);
    lk("pop_noop", 32'h200, 1'b0, 32'h204);
    upd("repush", 2'b10, 32'h1010, 1'b1, 32'h8000, 1'b1, 32'h8000, 1'b0, 32'h8000);
    lk("repush_top", 32'h200, 1'b1, 32'h1014);

    // Asynchronous reset in the middle of an update
    lk("pre_rst", 32'h40, 1'b1, 32'h90);
    upd_start(2'b00, 32'h40, 1'b1, 32'h90, 1'b1, 32'h90);
    #2;
    rst_n = 1'b0;
    lk("async_rst", 32'h40, 1'b0, 32'h44);
    upd_end();
    @(negedge clk);
    rst_n = 1'b1;
    lk("rst_40", 32'h40, 1'b0, 32'h44);
    lk("rst_200", 32'h200, 1'b0, 32'h204);
    lk("rst_1010", 32'h1010, 1'b0, 32'h1014);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
